// File: rtl/btn_1_4_debounce_pkg.sv
// Shared definitions for the four-button conditioning block.
//   NUM_BTN                 number of button channels
//   DEF_DEBOUNCE_CYCLES     default stable-cycle count to accept a new level
//   DEF_LONG_CYCLES         default held cycles before a long-press pulse
//   clog2 / max_u           constant helpers used to size counters
package btn_pkg;

  localparam int unsigned NUM_BTN             = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEF_LONG_CYCLES     = 1000000;

  // Bits needed to hold values 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (longint unsigned p = 1; p < longint'(v); p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_1_4_debounce_if.sv
// Button bus between the raw board inputs and the conditioned outputs.
//   btn_raw      raw active-high buttons (driven by the board side / master)
//   btn_level    debounced levels
//   btn_press    one-cycle pulse on accepted press
//   btn_release  one-cycle pulse on accepted release
//   btn_toggle   per-button toggle latch, flips on each press
//   long_press   one-cycle pulse after a long hold (zero unless BTN_LONG_PRESS_EN)
interface btn_1_4_debounce_if;
  import btn_pkg::*;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_toggle;
  logic [NUM_BTN-1:0] long_press;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_toggle, long_press
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_toggle, long_press
  );

endinterface

// File: rtl/btn_1_4_debounce_ch.sv
// One button channel: 2-FF synchronizer, counter debouncer, press/release
// pulses, toggle latch and (with BTN_LONG_PRESS_EN defined) a hold counter
// producing a single long-press pulse per press.
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   btn_raw      raw asynchronous button input
//   btn_level    debounced level
//   btn_press    one-cycle pulse, asserted together with the new level 1
//   btn_release  one-cycle pulse, asserted together with the new level 0
//   btn_toggle   flips on the edge after btn_press is high
//   long_press   one-cycle pulse when the hold counter reaches LONG_CYCLES-1
module btn_debounce_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
`ifdef BTN_LONG_PRESS_EN
  parameter int unsigned LONG_CYCLES     = 1000000,
`endif
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_toggle,
  output logic long_press
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync        <= '0;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_toggle  <= 1'b0;
    end else begin
      sync        <= {sync[0], btn_raw};
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      if (btn_press) begin
        btn_toggle <= ~btn_toggle;
      end
      // Any sample matching the current level restarts the count.
      if (sync[1] == btn_level) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        btn_level   <= sync[1];
        btn_press   <= sync[1];
        btn_release <= ~sync[1];
        cnt         <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0] hcnt;

  // hcnt parks at LONG_CYCLES after firing so the pulse cannot repeat
  // within the same press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt       <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!btn_level) begin
        hcnt <= '0;
      end else if (hcnt < LONG_LAST) begin
        hcnt <= hcnt + CNT_W'(1);
      end else if (hcnt == LONG_LAST) begin
        long_press <= 1'b1;
        hcnt       <= LONG_SAT;
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/btn_1_4_debounce.sv
// Four-channel push-button conditioner. Each raw button is synchronized,
// debounced, and turned into level / press / release / toggle outputs.
// Optional long-press detection is built when BTN_LONG_PRESS_EN is defined;
// otherwise long_press is constant zero.
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   btn_1_4_debounce_if.slave: btn_raw in; btn_level, btn_press,
//         btn_release, btn_toggle, long_press out (4 bits each)
module btn_1_4_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  btn_1_4_debounce_if.slave    bus
);

  localparam int unsigned CNT_W = clog2(max_u(DEBOUNCE_CYCLES, LONG_CYCLES) + 1);

  logic [NUM_BTN-1:0] level_v;
  logic [NUM_BTN-1:0] press_v;
  logic [NUM_BTN-1:0] release_v;
  logic [NUM_BTN-1:0] toggle_v;
  logic [NUM_BTN-1:0] long_v;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef BTN_LONG_PRESS_EN
      .LONG_CYCLES     (LONG_CYCLES),
`endif
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst),
      .btn_raw     (bus.btn_raw[i]),
      .btn_level   (level_v[i]),
      .btn_press   (press_v[i]),
      .btn_release (release_v[i]),
      .btn_toggle  (toggle_v[i]),
      .long_press  (long_v[i])
    );
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = release_v;
  assign bus.btn_toggle  = toggle_v;
  assign bus.long_press  = long_v;

endmodule
